muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle unsigned multiply/divide unit that takes over the ALU's multiply (op 2) and divide (op 3) encodings, so the ALU no longer needs a single-cycle multiplier or divider.
- The ALU computes every op within the cycle. This block accepts an operation on a start pulse, computes iteratively over 32 cycles, and returns a result pair with a done pulse.
- Results go to HI/LO, MIPS-style. The controller stalls on busy.

Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits.
- OP_MUL, 4'd2, op code selecting multiply; same encoding as the ALU.
- OP_DIV, 4'd3, op code selecting divide; same encoding as the ALU.

Ports:
- clk  input  1  Single clock. All state updates on the rising edge.
- rst  input  1  Asynchronous, active-high reset.
- start  input  1  Request strobe. Sampled only in IDLE.
- op  input  4  Operation code. Only OP_MUL and OP_DIV are accepted.
- a  input  WIDTH  Multiplicand / dividend.
- b  input  WIDTH  Multiplier / divisor.
- busy  output  1  High while an operation is in progress.
- done  output  1  One-cycle pulse when hi/lo hold the new result.
- hi  output  WIDTH  Product upper half, or remainder.
- lo  output  WIDTH  Product lower half, or quotient.
- div_by_zero  output  1  Set with done when a divide had b==0; held until the next accepted op.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0.
  - Iteration counter and operand registers cleared; any operation in progress is abandoned.
- States:
  - IDLE
  - MUL: 32 iterations.
  - DIV: 32 iterations.
  - FIN: 1 cycle.
- Accept:
  - Condition: start=1 and op in {OP_MUL, OP_DIV} at a clock edge while in IDLE.
  - At that edge, a and b are latched, the counter is set to 0, state goes to MUL or DIV, and busy goes to 1.
  - On accept, div_by_zero clears to 0.
  - start with any other op, or start while not in IDLE, is ignored with no state change.
- Operands: a and b may change freely after the accept edge; only the latched copies are used.
- MUL (unsigned shift-add):
  - Each cycle performs one iteration over a 2*WIDTH accumulator and increments the counter.
  - After iteration 31 (counter==31), state goes to FIN.
- DIV (unsigned restoring):
  - Each cycle shifts the remainder/quotient pair left by 1 and trial-subtracts the divisor.
  - If no borrow, the difference is kept and the quotient bit is set to 1; otherwise the remainder is restored and the quotient bit is 0.
  - After 32 iterations, state goes to FIN.
- FIN (one cycle):
  - At the edge entering FIN, hi/lo are written:
    - MUL: {hi,lo} = a*b, full 64-bit product.
    - DIV: lo = a/b, hi = a%b.
  - In FIN, done=1 and busy=0. Next edge returns to IDLE with done=0.
  - A start presented during FIN is ignored; it is accepted only from IDLE.
- Latency:
  - Accept edge T. busy=1 for cycles T+1..T+32.
  - done=1 in cycle T+33 (the cycle after edge T+32), with hi/lo valid from that cycle.
  - Minimum issue interval is 34 cycles.
- Divide by zero:
  - Full 32-cycle latency, no early exit.
  - Result is lo=all ones, hi=a (the natural restoring-divider result).
  - div_by_zero=1 from the FIN cycle onward, until the next accepted op.
- hi/lo hold their value between operations and change only on the FIN-entry edge or on reset.
- All arithmetic is unsigned; no overflow flag (the 64-bit product always fits in hi:lo).

Decomposition:
- Shared package:
  - ALU op code constants (ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, XOR=6), used by the ALU, the controller, and this block.
  - State encoding for IDLE/MUL/DIV/FIN.
  - WIDTH default.
- One sub-module, muldiv_step: purely combinational single iteration.
  - Inputs: mode and current accumulator/remainder/quotient/operand.
  - Outputs: next-iteration values.
  - The FSM, counter and registers stay in muldiv_unit.

Test Plan:
- MUL full-width: a=0xFFFFFFFF, b=0xFFFFFFFF, op=2, start -> done exactly 33 cycles after accept edge; hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0; busy high exactly 32 cycles.
- DIV normal: a=100, b=7, op=3 -> lo=14, hi=2, div_by_zero=0. Repeat with a=0x80000000, b=1 -> lo=0x80000000, hi=0.
- DIV by zero: a=5, b=0, op=3 -> after 33 cycles lo=0xFFFFFFFF, hi=5, div_by_zero=1. A subsequent MUL accept clears div_by_zero to 0 at its accept edge.
- Ignored requests:
  - start with op=0 in IDLE -> busy stays 0, hi/lo unchanged.
  - During a MUL of 3*4, assert start with op=3, a=9, b=2 and change a/b mid-operation -> result still hi=0, lo=12; only one done pulse.
- Reset mid-operation: rst asserted asynchronously at cycle 10 of DIV 100/7 -> busy, done, hi, lo, div_by_zero all 0 immediately (before the next edge), no done pulse afterwards. A new MUL 6*7 after release gives lo=42.
- Back-to-back: issue MUL 2*3 and, in the cycle after done, DIV 9/4 -> first done gives lo=6; second accept succeeds from IDLE; second done gives lo=2, hi=1.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the ALU, the controller and the multi-cycle mul/div unit.
// Holds the ALU op encoding, the default operand width and the mul/div FSM states.
package muldiv_unit_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIN
    } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the controller (master) and muldiv_unit (slave).
// master drives start/op/a/b; slave returns busy/done/hi/lo/div_by_zero.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
// Ports: div_i selects divide, acc_i/acc_o = {hi-part, lo-part}, opnd_i = a (mul) or b (div).
module muldiv_step
    import muldiv_unit_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic           div_i,
    input  logic [2*W-1:0] acc_i,
    input  logic [W-1:0]   opnd_i,
    output logic [2*W-1:0] acc_o
);
    logic [W:0]   sum;
    logic [W:0]   rem_sh;
    logic [W-1:0] diff;
    logic         borrow;

    always_comb begin
        // mul: conditionally add multiplicand into upper half, then shift right
        sum    = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // div: remainder after shifting in the next dividend bit (W+1 bits)
        rem_sh = acc_i[2*W-1:W-1];
        borrow = rem_sh < {1'b0, opnd_i};
        // true difference always fits W bits when there is no borrow
        diff   = rem_sh[W-1:0] - opnd_i;
        if (!div_i) begin
            acc_o = {sum, acc_i[W-1:1]};
        end else if (!borrow) begin
            acc_o = {diff, acc_i[W-2:0], 1'b1};
        end else begin
            acc_o = {rem_sh[W-1:0], acc_i[W-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide: 32 iterations, results to HI/LO.
// Ports: clk, rst (async active-high), bus (muldiv_unit_if.slave).
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, step_acc;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;
    logic             is_mul;
    logic             accept;

    muldiv_step #(.W(WIDTH)) u_step (
        .div_i  (state_q == ST_DIV),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc)
    );

    assign is_mul = bus.op == OP_MUL;
    assign accept = bus.start && (is_mul || bus.op == OP_DIV);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = is_mul ? ST_MUL : ST_DIV;
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    // mul: acc low = multiplier; div: acc low = dividend
                    opnd_d  = is_mul ? bus.a : bus.b;
                    acc_d   = {{WIDTH{1'b0}}, is_mul ? bus.b : bus.a};
                end
            end
            ST_MUL, ST_DIV: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIN;
                    hi_d    = step_acc[2*WIDTH-1:WIDTH];
                    lo_d    = step_acc[WIDTH-1:0];
                    dz_d    = (state_q == ST_DIV) && (opnd_q == '0);
                end
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy        = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign bus.done        = state_q == ST_FIN;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dz_q;
endmodule
